// File: rtl/bus_cmd_master_pkg.sv
`default_nettype none
//==============================================================================
// Package  : bus_cmd_master_pkg
// Purpose  : Shared state encoding, opcodes and response codes for bus_cmd_master
// Revision : 1.0
//==============================================================================
package bus_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_BUS_WR = 3'd3,
        ST_BUS_RD = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] c_op_wr_default = 8'h57;
    localparam logic [7:0] c_op_rd_default = 8'h52;
    localparam logic [7:0] c_resp_ack      = 8'h4B;
    localparam logic [7:0] c_resp_err      = 8'hEE;

    // Frame fields arrive MSB first, so each new byte enters at the bottom.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] cur,
                                                  input logic [7:0]  b);
        return {cur[23:0], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cmd_master.sv
`default_nettype none
//==============================================================================
// Module   : bus_cmd_master
// Purpose  : Turns a UART byte stream into single 32-bit peripheral bus cycles
// Revision : 1.0
//==============================================================================
module bus_cmd_master
    import bus_cmd_master_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] OP_WR          = c_op_wr_default,
    parameter logic [7:0] OP_RD          = c_op_rd_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        drop
);

    localparam int                 c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYCLES);

    state_t             r_state;
    logic               r_is_write;
    logic [1:0]         r_byte_cnt;
    logic [1:0]         r_resp_cnt;
    logic [c_tmo_w-1:0] r_tmo;
    logic [31:0]        r_resp;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic w_in_frame;
    logic w_timeout;
    logic w_accept;
    logic w_discard_state;

    // r_tmo counts idle cycles since the last accepted byte; the cycle in which
    // it reaches TIMEOUT_CYCLES aborts the frame, so any byte in it is lost.
    assign w_in_frame      = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timeout       = w_in_frame && (r_tmo == c_tmo_max);
    assign w_accept        = w_in_frame && rx_valid && !w_timeout;
    assign w_discard_state = (r_state == ST_BUS_WR) || (r_state == ST_BUS_RD) ||
                             (r_state == ST_RESP);

    assign tx_valid = (r_state == ST_RESP);
    assign tx_data  = r_resp[31:24];
    assign rd       = (r_state == ST_BUS_RD);
    assign wr       = (r_state == ST_BUS_WR);
    assign busy     = (r_state != ST_IDLE);
    assign drop     = rx_valid && (w_discard_state || w_timeout);
    assign addr     = r_addr;
    assign wdata    = r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_resp_cnt <= 2'd0;
            r_tmo      <= '0;
            r_resp     <= 32'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                            r_is_write <= (rx_data == OP_WR);
                            r_byte_cnt <= 2'd0;
                            r_tmo      <= '0;
                            r_state    <= ST_ADDR;
                        end else begin
                            r_resp     <= {c_resp_err, 24'h0};
                            r_resp_cnt <= 2'd0;
                            r_state    <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_tmo      <= '0;
                        r_addr     <= shift_in_byte(r_addr, rx_data);
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= r_is_write ? ST_DATA : ST_BUS_RD;
                        end
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end

                ST_DATA: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_tmo      <= '0;
                        r_wdata    <= shift_in_byte(r_wdata, rx_data);
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= ST_BUS_WR;
                        end
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end

                ST_BUS_WR: begin
                    r_resp     <= {c_resp_ack, 24'h0};
                    r_resp_cnt <= 2'd0;
                    r_state    <= ST_RESP;
                end

                ST_BUS_RD: begin
                    r_resp     <= rdata;
                    r_resp_cnt <= 2'd3;
                    r_state    <= ST_RESP;
                end

                // r_resp_cnt holds the number of bytes still queued behind tx_data.
                ST_RESP: begin
                    if (tx_ready) begin
                        r_resp <= {r_resp[23:0], 8'h00};
                        if (r_resp_cnt == 2'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_resp_cnt <= r_resp_cnt - 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_cmd_master.sv
`default_nettype none
//==============================================================================
// Module   : tb_bus_cmd_master
// Purpose  : Self-checking bench: frame-level scoreboard plus randomized frames
// Revision : 1.0
//==============================================================================
module tb_bus_cmd_master;

    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        drop;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    bit          exp_drop_now;
    bit          prev_stall;
    logic [7:0]  prev_data;
    int          ready_mode;
    int          stall_cnt;

    bus_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .drop     (drop)
    );

    // Peripheral model: a fixed register at 0x40000010, a hash everywhere else.
    function automatic logic [31:0] periph_read(input logic [31:0] a);
        if (a == 32'h4000_0010) return 32'h0000_003C;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rdata = rd ? periph_read(addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e64;
        logic [31:0] e32;
        logic [7:0]  e8;
        if (!reset) begin
            check("reset_ctl", 96'({tx_valid, rd, wr, busy, drop, tx_data}), 96'(0));
            check("reset_bus", 96'({addr, wdata}), 96'(0));
            prev_stall = 1'b0;
        end else begin
            check("drop", 96'(drop), 96'(exp_drop_now));
            check("rd_wr_excl", 96'(rd & wr), 96'(0));
            if (tx_valid || rd || wr) check("busy_active", 96'(busy), 96'(1));
            if (prev_stall) check("tx_hold", 96'({tx_valid, tx_data}), 96'({1'b1, prev_data}));
            if (wr) begin
                if (exp_wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_unexpected: got wr pulse addr=%h wdata=%h, required none", addr, wdata);
                end else begin
                    e64 = exp_wr_q.pop_front();
                    check("wr_bus", 96'({addr, wdata}), 96'(e64));
                end
            end
            if (rd) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_unexpected: got rd pulse addr=%h, required none", addr);
                end else begin
                    e32 = exp_rd_q.pop_front();
                    check("rd_addr", 96'(addr), 96'(e32));
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
                end else begin
                    e8 = exp_tx_q.pop_front();
                    check("tx_byte", 96'(tx_data), 96'(e8));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // tx_ready: 0 = random, 1 = ten-cycle stall per byte, other = always ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'($urandom_range(0, 1));
            1: begin
                if (tx_ready) begin
                    tx_ready  = 1'b0;
                    stall_cnt = 0;
                end else if (tx_valid) begin
                    stall_cnt++;
                    if (stall_cnt >= 10) tx_ready = 1'b1;
                end
            end
            default: tx_ready = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit discard);
        repeat (gap) tick();
        rx_valid     = 1'b1;
        rx_data      = b;
        exp_drop_now = discard;
        tick();
        rx_valid     = 1'b0;
        exp_drop_now = 1'b0;
    endtask

    function automatic int pick_gap(input int fixed_gap);
        if (fixed_gap >= 0) return fixed_gap;
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, T - 1));
        return int'($urandom_range(0, 2));
    endfunction

    // Model: a complete frame yields one bus cycle and a fixed response.
    task automatic run_frame(input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] d, input int fixed_gap);
        logic [31:0] r;
        if (op == 8'h57) begin
            exp_wr_q.push_back({a, d});
            exp_tx_q.push_back(8'h4B);
        end else if (op == 8'h52) begin
            exp_rd_q.push_back(a);
            r = periph_read(a);
            for (int i = 3; i >= 0; i--) exp_tx_q.push_back(r[8*i +: 8]);
        end else begin
            exp_tx_q.push_back(8'hEE);
        end
        send_byte(op, 0, 1'b0);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], pick_gap(fixed_gap), 1'b0);
            if (op == 8'h57)
                for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], pick_gap(fixed_gap), 1'b0);
        end
    endtask

    task automatic wait_resp(input int inject_pct);
        bit injected;
        int budget;
        injected = 1'b0;
        budget   = 3000;
        while (exp_tx_q.size() != 0 && budget > 0) begin
            if (!injected && tx_valid && int'($urandom_range(1, 100)) <= inject_pct) begin
                injected = 1'b1;
                send_byte(8'($urandom), 0, 1'b1);
            end else begin
                tick();
            end
            budget--;
        end
        check("resp_drained", 96'(exp_tx_q.size()), 96'(0));
        exp_tx_q.delete();
        repeat (2) tick();
        check("idle_after_resp", 96'({busy, tx_valid}), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] wseq [9];
        logic [7:0] rseq [5];
        logic [7:0] op;
        int         kind;

        rx_valid = 1'b0; rx_data = 8'h00; exp_drop_now = 1'b0;
        tx_ready = 1'b0; stall_cnt = 0; ready_mode = 2;
        prev_stall = 1'b0; prev_data = 8'h00;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("post_reset_idle", 96'({busy, tx_valid, rd, wr}), 96'(0));

        // Literal write frame and its ACK.
        wseq = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hA5};
        exp_wr_q.push_back({32'h4000_000C, 32'h0000_00A5});
        exp_tx_q.push_back(8'h4B);
        foreach (wseq[i]) send_byte(wseq[i], 1, 1'b0);
        wait_resp(0);

        // Literal read frame; response bytes written out by hand.
        rseq = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
        exp_rd_q.push_back(32'h4000_0010);
        exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'h3C);
        ready_mode = 0;
        foreach (rseq[i]) send_byte(rseq[i], 0, 1'b0);
        wait_resp(0);

        // Unknown opcode, then a normal frame.
        exp_tx_q.push_back(8'hEE);
        send_byte(8'h33, 0, 1'b0);
        wait_resp(0);
        run_frame(8'h57, 32'h1234_5678, 32'hCAFE_F00D, -1);
        wait_resp(0);

        // Abandoned read frame times out silently.
        send_byte(8'h52, 0, 1'b0);
        send_byte(8'h40, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        repeat (T + 4) tick();
        check("timeout_idle", 96'({busy, tx_valid}), 96'(0));
        run_frame(8'h52, 32'h0000_0100, 32'h0, -1);
        wait_resp(0);

        // Largest tolerated gap is T-1 idle cycles; a gap of T loses the byte.
        run_frame(8'h52, 32'hA0B0_C0D0, 32'h0, T - 1);
        wait_resp(0);
        send_byte(8'h57, 0, 1'b0);
        send_byte(8'h40, T, 1'b1);
        check("timeout_drop_idle", 96'(busy), 96'(0));
        run_frame(8'h57, 32'h0000_0004, 32'h0000_0099, -1);
        wait_resp(0);

        // Stalled read response with a byte arriving mid-response.
        ready_mode = 1;
        exp_rd_q.push_back(32'h4000_0010);
        exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'h3C);
        foreach (rseq[i]) send_byte(rseq[i], 0, 1'b0);
        wait_resp(100);

        // Reset after the sixth byte of a write frame.
        ready_mode = 2;
        for (int i = 0; i < 6; i++) send_byte(wseq[i], 0, 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("reset_abort_idle", 96'({busy, wr, rd, tx_valid}), 96'(0));
        run_frame(8'h57, 32'h5555_AAAA, 32'h0F0F_0F0F, -1);
        wait_resp(0);

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            kind       = int'($urandom_range(0, 4));
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            if (kind < 2)      op = 8'h57;
            else if (kind < 4) op = 8'h52;
            else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
            end
            run_frame(op, $urandom, $urandom, -1);
            wait_resp(30);
        end

        check("queues_empty", 96'(exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
